// File: rtl/host_arb_pkg.sv
// ============================================================================
// Module      : host_arb_pkg
// Description : Shared types and constants for the host-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package host_arb_pkg;

  // Upper bound on the number of requesters the arbiter supports.
  localparam int MaxNumReq = 4;

  // One TL-UL A-channel request as presented to the host adapter.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } host_req_t;

  // One D-channel response as returned by the host adapter.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        intg_err;
  } host_rsp_t;

endpackage

`default_nettype wire

// File: rtl/host_arb_id_fifo.sv
// ============================================================================
// Module      : host_arb_id_fifo
// Description : In-order FIFO of requester IDs for granted, unanswered
//               transactions. Reports head, full, empty and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module host_arb_id_fifo #(
  parameter int Width = 1,
  parameter int Depth = 2,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push while full is only accepted when a pop frees the slot in the same cycle.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  // Storage, wrapping pointers and a saturating-by-construction occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CntW'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/host_port_arbiter.sv
// ============================================================================
// Module      : host_port_arbiter
// Description : Round-robin arbiter sharing one TL-UL host adapter port
//               between NumReq masters. Holds the A-channel until granted
//               and routes responses back through an in-order ID FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module host_port_arbiter
  import host_arb_pkg::*;
#(
  parameter int NumReq         = 2,
  parameter int MaxOutstanding = 2,
  localparam int IdW           = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // Requester side
  input  logic [NumReq-1:0]    req_i,
  output logic [NumReq-1:0]    gnt_o,
  input  logic [NumReq*32-1:0] addr_i,
  input  logic [NumReq-1:0]    we_i,
  input  logic [NumReq*32-1:0] wdata_i,
  input  logic [NumReq*4-1:0]  be_i,
  output logic [NumReq-1:0]    valid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic                 intg_err_o,
  // Host adapter side
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic [31:0]          addr_o,
  output logic                 we_o,
  output logic [31:0]          wdata_o,
  output logic [3:0]           be_o,
  input  logic                 valid_i,
  input  logic [31:0]          rdata_i,
  input  logic                 err_i,
  input  logic                 intg_err_i,
  // Status
  output logic                 busy_o,
  output logic                 spurious_rsp_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  host_req_t       req_array [NumReq];
  host_req_t       sel_req;
  host_rsp_t       rsp;

  logic [IdW-1:0]  ptr_q, ptr_d;
  logic            lock_q;
  logic [IdW-1:0]  lock_id_q;
  logic            spurious_q;

  logic            found;
  logic [IdW-1:0]  found_id;
  logic [IdW-1:0]  sel_id;
  logic            grant;
  logic            pop;

  logic [IdW-1:0]  fifo_head;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  // Unpack the flat requester buses into one struct per requester.
  for (genvar k = 0; k < NumReq; k++) begin : g_unpack
    assign req_array[k] = '{addr:  addr_i[32*k +: 32],
                            we:    we_i[k],
                            wdata: wdata_i[32*k +: 32],
                            be:    be_i[4*k +: 4]};
  end

  // Round-robin search: first asserted request at or after ptr, with wrap.
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    found_id = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = (int'(ptr_q) + i) % NumReq;
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        found_id = IdW'(idx);
      end
    end
  end

  // A lock freezes the selection; a full FIFO blocks any new selection.
  assign sel_id = lock_q ? lock_id_q : found_id;
  assign req_o  = lock_q | (found & ~fifo_full);
  assign grant  = req_o & gnt_i;
  assign gnt_o  = grant ? (NumReq'(1) << sel_id) : '0;
  assign ptr_d  = (int'(sel_id) == NumReq - 1) ? '0 : sel_id + IdW'(1);

  // A-channel mux; idle outputs read as zero when nothing is requested.
  always_comb begin
    sel_req = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (req_o && (IdW'(k) == sel_id)) begin
        sel_req = req_array[k];
      end
    end
  end

  assign addr_o  = sel_req.addr;
  assign we_o    = sel_req.we;
  assign wdata_o = sel_req.wdata;
  assign be_o    = sel_req.be;

  // Response path: data is broadcast, valid is steered to the oldest ID.
  assign rsp        = '{rdata: rdata_i, err: err_i, intg_err: intg_err_i};
  assign rdata_o    = rsp.rdata;
  assign err_o      = rsp.err;
  assign intg_err_o = rsp.intg_err;

  assign pop     = valid_i & ~fifo_empty;
  assign valid_o = pop ? (NumReq'(1) << fifo_head) : '0;

  assign busy_o         = (fifo_count != '0);
  assign spurious_rsp_o = spurious_q;

  // Priority pointer, A-channel lock and the spurious-response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      spurious_q <= 1'b0;
    end else begin
      spurious_q <= valid_i & fifo_empty;
      if (grant) begin
        lock_q <= 1'b0;
        ptr_q  <= ptr_d;
      end else if (req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel_id;
      end
    end
  end

  host_arb_id_fifo #(
    .Width (IdW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (sel_id),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_host_port_arbiter.sv
// ============================================================================
// Module      : tb_host_port_arbiter
// Description : Directed self-checking bench for host_port_arbiter
//               (NumReq=2, MaxOutstanding=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_host_port_arbiter;

  localparam int NR = 2;
  localparam int MO = 2;

  logic            clk, rst_n;
  logic [NR-1:0]   req_i, gnt_o, we_i, valid_o;
  logic [NR*32-1:0] addr_i, wdata_i;
  logic [NR*4-1:0] be_i;
  logic [31:0]     rdata_o, addr_o, wdata_o, rdata_i;
  logic            err_o, intg_err_o, req_o, gnt_i, we_o, valid_i, err_i, intg_err_i;
  logic [3:0]      be_o;
  logic            busy_o, spurious_rsp_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] A0 = 32'h1000_0004;
  localparam logic [31:0] A1 = 32'h2000_0008;

  host_port_arbiter #(.NumReq(NR), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .valid_o(valid_o), .rdata_o(rdata_o),
    .err_o(err_o), .intg_err_o(intg_err_o), .req_o(req_o), .gnt_i(gnt_i),
    .addr_o(addr_o), .we_o(we_o), .wdata_o(wdata_o), .be_o(be_o),
    .valid_i(valid_i), .rdata_i(rdata_i), .err_i(err_i), .intg_err_i(intg_err_i),
    .busy_o(busy_o), .spurious_rsp_o(spurious_rsp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_i = '0; gnt_i = 1'b0; valid_i = 1'b0;
    rdata_i = '0; err_i = 1'b0; intg_err_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_o got=%b exp=0", req_o); end
    n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_o got=%b exp=00", gnt_o); end
    n_checks++; if (valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_valid_o got=%b exp=00", valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++; if (spurious_rsp_o !== 1'b0) begin n_fail++; $display("FAIL reset_spurious got=%b exp=0", spurious_rsp_o); end
    n_checks++; if (addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", addr_o); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_i = 2'b01;
    @(negedge clk);
    n_checks++; if (req_o !== 1'b1) begin n_fail++; $display("FAIL single_req got=%b exp=1", req_o); end
    n_checks++; if (addr_o !== A0) begin n_fail++; $display("FAIL single_addr got=%h exp=%h", addr_o, A0); end
    n_checks++; if (be_o !== 4'h3 || we_o !== 1'b1) begin n_fail++; $display("FAIL single_be_we got=%h/%b exp=3/1", be_o, we_o); end
    n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL single_nognt got=%b exp=00", gnt_o); end
    tick();
    gnt_i = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL single_gnt got=%b exp=01", gnt_o); end
    tick();
    req_i = '0; gnt_i = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy_o); end
    n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL single_gnt_once got=%b exp=00", gnt_o); end
    tick();
    valid_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (valid_o !== 2'b01) begin n_fail++; $display("FAIL single_valid got=%b exp=01", valid_o); end
    n_checks++; if (rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata got=%h exp=deadbeef", rdata_o); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_clear got=%b exp=0", busy_o); end
    n_checks++; if (valid_o !== 2'b00) begin n_fail++; $display("FAIL single_valid_once got=%b exp=00", valid_o); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt [5];
    logic [1:0]  exp_val [5];
    logic [31:0] exp_adr [5];
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    exp_val = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    exp_adr = '{A0, A1, A0, A1, 32'h0};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req_i   = (c < 4) ? 2'b11 : 2'b00;
      gnt_i   = (c < 4);
      valid_i = (c >= 1);
      @(negedge clk);
      n_checks++; if (gnt_o !== exp_gnt[c]) begin n_fail++; $display("FAIL contention_gnt[%0d] got=%b exp=%b", c, gnt_o, exp_gnt[c]); end
      n_checks++; if (valid_o !== exp_val[c]) begin n_fail++; $display("FAIL contention_valid[%0d] got=%b exp=%b", c, valid_o, exp_val[c]); end
      n_checks++; if (addr_o !== exp_adr[c]) begin n_fail++; $display("FAIL contention_addr[%0d] got=%h exp=%h", c, addr_o, exp_adr[c]); end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL contention_drain got=%b exp=0", busy_o); end
  endtask

  task automatic test_lock();
    do_reset();
    req_i = 2'b10;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) req_i = 2'b11;
      @(negedge clk);
      n_checks++; if (addr_o !== A1) begin n_fail++; $display("FAIL lock_addr[%0d] got=%h exp=%h", c, addr_o, A1); end
      n_checks++; if (req_o !== 1'b1 || gnt_o !== 2'b00) begin n_fail++; $display("FAIL lock_hold[%0d] got=%b/%b exp=1/00", c, req_o, gnt_o); end
      tick();
    end
    gnt_i = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt_o !== 2'b10) begin n_fail++; $display("FAIL lock_gnt got=%b exp=10", gnt_o); end
    n_checks++; if (we_o !== 1'b0 || be_o !== 4'hC) begin n_fail++; $display("FAIL lock_we_be got=%b/%h exp=0/c", we_o, be_o); end
    tick();
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    req_i = 2'b11; gnt_i = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (req_o !== 1'b0 || gnt_o !== 2'b00) begin n_fail++; $display("FAIL full_stall got=%b/%b exp=0/00", req_o, gnt_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL full_busy got=%b exp=1", busy_o); end
    tick();
    valid_i = 1'b1;
    @(negedge clk);
    n_checks++; if (valid_o !== 2'b01) begin n_fail++; $display("FAIL full_valid got=%b exp=01", valid_o); end
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL full_req_same_cycle got=%b exp=0", req_o); end
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (req_o !== 1'b1 || gnt_o !== 2'b01) begin n_fail++; $display("FAIL full_resume got=%b/%b exp=1/01", req_o, gnt_o); end
    tick();
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    valid_i = 1'b1;
    @(negedge clk);
    n_checks++; if (valid_o !== 2'b00) begin n_fail++; $display("FAIL spur_valid got=%b exp=00", valid_o); end
    n_checks++; if (spurious_rsp_o !== 1'b0) begin n_fail++; $display("FAIL spur_early got=%b exp=0", spurious_rsp_o); end
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (spurious_rsp_o !== 1'b1) begin n_fail++; $display("FAIL spur_pulse got=%b exp=1", spurious_rsp_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL spur_busy got=%b exp=0", busy_o); end
    tick();
    @(negedge clk);
    n_checks++; if (spurious_rsp_o !== 1'b0) begin n_fail++; $display("FAIL spur_clear got=%b exp=0", spurious_rsp_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i = 2'b11; gnt_i = 1'b1;
    tick(); tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy got=%b exp=1", busy_o); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
    n_checks++; if (req_o !== 1'b0 || gnt_o !== 2'b00 || valid_o !== 2'b00) begin n_fail++; $display("FAIL midrst_outs got=%b/%b/%b exp=0/00/00", req_o, gnt_o, valid_o); end
    tick();
    rst_n = 1'b1;
    valid_i = 1'b1;
    @(negedge clk);
    n_checks++; if (valid_o !== 2'b00) begin n_fail++; $display("FAIL midrst_late_valid got=%b exp=00", valid_o); end
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (spurious_rsp_o !== 1'b1) begin n_fail++; $display("FAIL midrst_spurious got=%b exp=1", spurious_rsp_o); end
    tick();
  endtask

  initial begin
    addr_i  = {A1, A0};
    wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
    we_i    = 2'b01;
    be_i    = {4'hC, 4'h3};
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_full();
    test_spurious();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
